// File: rtl/conv_pkg.sv
// Shared code definition for the K=4 rate-1/2 convolutional encoder and its Viterbi decoder.
package conv_pkg;

  localparam int          K        = 4;
  localparam logic [K-1:0] G0      = 4'b1101;
  localparam logic [K-1:0] G1      = 4'b1111;
  localparam int          TAIL_LEN = K - 1;

  typedef enum logic [1:0] {IDLE, DATA, TAIL} enc_state_t;

  // Window is {u, s0, s1, s2} with the newest bit in the MSB.
  function automatic logic parity(input logic [K-1:0] g, input logic [K-1:0] win);
    return ^(g & win);
  endfunction

endpackage

// File: rtl/conv_encoder_err_lfsr.sv
// Channel-error LFSR (x^16+x^14+x^13+x^11+1), present only when ERR_INJECT_EN is defined.
`ifdef ERR_INJECT_EN
module err_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reload,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (reload)    lfsr_d = SEED;
    else if (step) lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= SEED;
    else      lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;

endmodule
`endif

// File: rtl/conv_encoder.sv
// Framed rate-1/2 K=4 convolutional encoder with zero-tail termination.
// Optional ERR_INJECT_EN macro adds LFSR-driven inversion of out_sym[0].
module conv_encoder
  import conv_pkg::*;
#(
  parameter int         LEN_W      = 10,
  parameter logic [7:0] ERR_THRESH = 8'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic [1:0]       out_sym,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  enc_state_t       state_q, state_d;
  logic [2:0]       sr_q, sr_d;       // {s2, s1, s0}
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       tail_q, tail_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       out_sym_q, out_sym_d;
  logic             out_last_q, out_last_d;

  logic             slot_free, load, u, fin, err_flip;
  logic [K-1:0]     win;

  assign slot_free = !out_valid_q || out_ready;
  assign win       = {u, sr_q[0], sr_q[1], sr_q[2]};

`ifdef ERR_INJECT_EN
  logic [15:0] lfsr;

  err_lfsr u_err_lfsr (
    .clk    (clk),
    .rst    (rst),
    .reload (!enable),
    .step   (load),
    .state  (lfsr)
  );

  assign err_flip = lfsr[7:0] < ERR_THRESH;
`else
  localparam logic [7:0] thresh_unused = ERR_THRESH;
  assign err_flip = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    tail_d      = tail_q;
    out_valid_d = out_valid_q;
    out_sym_d   = out_sym_q;
    out_last_d  = out_last_q;
    load        = 1'b0;
    u           = 1'b0;
    fin         = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (!enable) begin
      state_d     = IDLE;
      sr_d        = '0;
      cnt_d       = '0;
      tail_d      = '0;
      out_valid_d = 1'b0;
      out_sym_d   = 2'b00;
      out_last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          len_d   = frame_len;
          cnt_d   = '0;
          sr_d    = '0;
          tail_d  = '0;
          state_d = (frame_len == '0) ? TAIL : DATA;
        end
        DATA: if (in_valid && slot_free) begin
          load  = 1'b1;
          u     = in_bit;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) state_d = TAIL;
        end
        TAIL: if (slot_free) begin
          load   = 1'b1;
          tail_d = tail_q + 1'b1;
          if (tail_q == 2'(TAIL_LEN - 1)) begin
            fin     = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Every load replaces the pending symbol, so out_last follows the new one.
    if (load) begin
      out_valid_d = 1'b1;
      out_sym_d   = {parity(G0, win), parity(G1, win) ^ err_flip};
      out_last_d  = fin;
      sr_d        = {sr_q[1:0], u};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      out_sym_q   <= 2'b00;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      tail_q      <= tail_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = enable && (state_q == DATA) && slot_free;
  assign out_valid = out_valid_q;
  assign out_sym   = out_sym_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);

endmodule
